// File: rtl/nios_ocimem_ctrl.sv
// Debug RAM controller: turns JTAG debug-module strobes into RAM accesses and
// shares the single-port RAM with the CPU's Avalon debug slave.
module nios_ocimem_ctrl #(
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest
);
    typedef enum logic [1:0] {IDLE, REQ, ACC, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] mon_a_reg;
    logic              op_read;
    logic              cpu_rd_vld_p1;

    logic              q_b, q_a, q_n, load_a, queue_req, accept, drop;
    logic              cpu_req, cpu_grant;

    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_q;
    logic [3:0]        ram_be;
    logic [31:0]       mem [2**ADDR_W];

    logic              unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    // Strobe priority: ocimem_b > ocimem_a > no_action_a
    assign q_b       = take_action_ocimem_b;
    assign load_a    = !take_action_ocimem_b && take_action_ocimem_a;
    assign q_a       = load_a && jdo[35];
    assign q_n       = !take_action_ocimem_b && !take_action_ocimem_a && take_no_action_ocimem_a;
    assign queue_req = q_b || q_a || q_n;
    assign accept    = queue_req && (state == IDLE);
    assign drop      = queue_req && (state != IDLE);

    // A pending JTAG op (REQ) or JTAG access (ACC) locks the CPU out.
    assign cpu_req   = (avs_read || avs_write) && !cpu_rd_vld_p1;
    assign cpu_grant = cpu_req && (state != REQ) && (state != ACC);

    assign avs_waitrequest = (state == ACC) || (cpu_req && !(cpu_grant && avs_write));
    assign avs_readdata    = cpu_rd_vld_p1 ? ram_q : 32'h0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = REQ;
            REQ:     if (!cpu_rd_vld_p1) state_nxt = ACC;
            ACC:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = avs_address;
        ram_wdata = avs_writedata;
        ram_be    = avs_byteenable;
        if (state == ACC) begin
            ram_en    = 1'b1;
            ram_we    = !op_read;
            ram_addr  = mon_a_reg;
            ram_wdata = MonDReg;
            ram_be    = 4'hF;
        end else if (cpu_grant) begin
            ram_en    = 1'b1;
            ram_we    = avs_write;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_a_reg     <= '0;
            MonDReg       <= 32'h0;
            op_read       <= 1'b0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            cpu_rd_vld_p1 <= 1'b0;
        end else begin
            if (load_a && !drop) begin
                mon_a_reg <= jdo[ADDR_W+1:2];
            end else if (accept && q_n) begin
                mon_a_reg <= mon_a_reg + 1'b1;
            end else if (state == DONE && !op_read) begin
                mon_a_reg <= mon_a_reg + 1'b1;
            end

            if (accept && q_b) begin
                MonDReg <= jdo[34:3];
            end else if (state == DONE && op_read) begin
                MonDReg <= ram_q;
            end

            if (accept) begin
                op_read <= !q_b;
            end

            if (drop) begin
                monitor_error <= 1'b1;
            end else if (load_a) begin
                monitor_error <= 1'b0;
            end

            if (accept) begin
                monitor_ready <= 1'b0;
            end else if (state == DONE) begin
                monitor_ready <= 1'b1;
            end

            cpu_rd_vld_p1 <= cpu_grant && avs_read && !avs_write;
        end
    end

    // Single-port RAM; read-during-write returns the old word.
    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
                end
            end
            ram_q <= mem[ram_addr];
        end
    end

endmodule

// File: tb/tb_nios_ocimem_ctrl.sv
// Directed bench for nios_ocimem_ctrl: JTAG round trips, wrap, busy drop,
// CPU/JTAG arbitration, byte enables and asynchronous reset mid-access.
module tb_nios_ocimem_ctrl;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nios_ocimem_ctrl #(.ADDR_W(ADDR_W), .INIT_FILE("")) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic strobe_a(input logic [7:0] addr, input logic rd);
        jdo = '0;
        jdo[ADDR_W+1:2] = addr;
        jdo[35] = rd;
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [31:0] data);
        jdo = '0;
        jdo[34:3] = data;
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic strobe_n();
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (monitor_ready) break;
        end
        check(tag, {31'b0, monitor_ready}, 32'd1);
    endtask

    task automatic cpu_access(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] rdata, output int waits);
        logic w;
        w = 1'b1;
        waits = 0;
        rdata = '0;
        avs_address    = addr;
        avs_writedata  = wdata;
        avs_byteenable = be;
        avs_write      = wr;
        avs_read       = !wr;
        for (int i = 0; i < 20; i++) begin
            #4;
            w     = avs_waitrequest;
            rdata = avs_readdata;
            @(posedge clk);
            if (!w) break;
            waits++;
            @(negedge clk);
        end
        @(negedge clk);
        avs_write = 1'b0;
        avs_read  = 1'b0;
        check("cpu_complete", {31'b0, w}, 32'd0);
    endtask

    logic [31:0] rd;
    int          wt;

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_ready", {31'b0, monitor_ready}, 32'd1);
        check("rst_error", {31'b0, monitor_error}, 32'd0);
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_readdata", avs_readdata, 32'h0);
        check("rst_waitreq", {31'b0, avs_waitrequest}, 32'd0);

        // JTAG write/read round trip
        strobe_a(8'h10, 1'b0);
        check("rt_addr_only_ready", {31'b0, monitor_ready}, 32'd1);
        strobe_b(32'hDEADBEEF);
        check("rt_wr_busy", {31'b0, monitor_ready}, 32'd0);
        wait_ready("rt_wr_done");
        check("rt_wr_mondreg", MonDReg, 32'hDEADBEEF);
        strobe_b(32'h00000000);
        wait_ready("rt_wr2_done");
        check("rt_wr2_mondreg", MonDReg, 32'h0);
        cpu_access(1'b0, 8'h10, 32'h0, 4'h0, rd, wt);
        check("rt_cpu_rd10", rd, 32'hDEADBEEF);
        check("rt_cpu_rd_waits", wt, 32'd1);
        cpu_access(1'b0, 8'h11, 32'h0, 4'h0, rd, wt);
        check("rt_cpu_rd11_autoinc", rd, 32'h0);
        strobe_a(8'h10, 1'b1);
        check("rt_rd_t0_ready", {31'b0, monitor_ready}, 32'd0);
        repeat (2) @(negedge clk);
        check("rt_rd_t2_ready", {31'b0, monitor_ready}, 32'd0);
        @(negedge clk);
        check("rt_rd_t3_ready", {31'b0, monitor_ready}, 32'd1);
        check("rt_rd_t3_mondreg", MonDReg, 32'hDEADBEEF);
        strobe_n();
        wait_ready("rt_next_done");
        check("rt_next_mondreg", MonDReg, 32'h0);

        // Auto-increment and wrap
        strobe_a(8'hFF, 1'b0);
        strobe_b(32'h11111111);
        wait_ready("wrap_wr_done");
        cpu_access(1'b1, 8'h00, 32'h22222222, 4'hF, rd, wt);
        check("wrap_cpu_wr_waits", wt, 32'd0);
        strobe_a(8'hFF, 1'b1);
        wait_ready("wrap_rd_done");
        check("wrap_rd_ff", MonDReg, 32'h11111111);
        strobe_n();
        wait_ready("wrap_next_done");
        check("wrap_next_00", MonDReg, 32'h22222222);
        cpu_access(1'b0, 8'hFF, 32'h0, 4'h0, rd, wt);
        check("wrap_cpu_rd_ff", rd, 32'h11111111);

        // Busy drop: second ocimem_b lands while the first is in REQ
        strobe_a(8'h30, 1'b0);
        jdo = '0;
        jdo[34:3] = 32'hCAFEF00D;
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        jdo[34:3] = 32'h12345678;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        check("drop_error_set", {31'b0, monitor_error}, 32'd1);
        check("drop_mondreg_kept", MonDReg, 32'hCAFEF00D);
        wait_ready("drop_done");
        check("drop_error_sticky", {31'b0, monitor_error}, 32'd1);
        cpu_access(1'b0, 8'h30, 32'h0, 4'h0, rd, wt);
        check("drop_ram_first", rd, 32'hCAFEF00D);
        strobe_a(8'h30, 1'b1);
        check("drop_error_clear", {31'b0, monitor_error}, 32'd0);
        wait_ready("drop_rd_done");
        check("drop_rd_mondreg", MonDReg, 32'hCAFEF00D);

        // Arbitration: CPU read of 0x20 arrives while the JTAG write sits in REQ
        strobe_a(8'h20, 1'b0);
        strobe_b(32'h5A5AA5A5);
        cpu_access(1'b0, 8'h20, 32'h0, 4'h0, rd, wt);
        check("arb_cpu_data", rd, 32'h5A5AA5A5);
        check("arb_cpu_waits", wt, 32'd3);
        check("arb_jtag_ready", {31'b0, monitor_ready}, 32'd1);
        check("arb_jtag_mondreg", MonDReg, 32'h5A5AA5A5);
        strobe_a(8'h20, 1'b1);
        wait_ready("arb_rd_done");
        check("arb_jtag_rd", MonDReg, 32'h5A5AA5A5);

        // Byte enables
        strobe_a(8'h40, 1'b0);
        strobe_b(32'h00000000);
        wait_ready("be_clear_done");
        cpu_access(1'b1, 8'h40, 32'hAABBCCDD, 4'b0101, rd, wt);
        strobe_a(8'h40, 1'b1);
        wait_ready("be_rd_done");
        check("be_jtag_rd", MonDReg, 32'h00BB00DD);
        cpu_access(1'b0, 8'h40, 32'h0, 4'h0, rd, wt);
        check("be_cpu_rd", rd, 32'h00BB00DD);

        // Asynchronous reset in the ACC cycle, with monitor_error set
        cpu_access(1'b1, 8'h01, 32'h01010101, 4'hF, rd, wt);
        strobe_a(8'h50, 1'b0);
        jdo = '0;
        jdo[34:3] = 32'h77777777;
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        jdo[34:3] = 32'h88888888;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        check("rst_pre_error", {31'b0, monitor_error}, 32'd1);
        check("rst_pre_ready", {31'b0, monitor_ready}, 32'd0);
        check("rst_pre_mondreg", MonDReg, 32'h77777777);
        reset_n = 1'b0;
        #1;
        check("rst_mid_ready", {31'b0, monitor_ready}, 32'd1);
        check("rst_mid_error", {31'b0, monitor_error}, 32'd0);
        check("rst_mid_mondreg", MonDReg, 32'h0);
        check("rst_mid_waitreq", {31'b0, avs_waitrequest}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        strobe_n();
        wait_ready("rst_post_done");
        check("rst_post_monareg0", MonDReg, 32'h01010101);
        check("rst_post_error", {31'b0, monitor_error}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nios_ocimem_ctrl.md
Name: nios_ocimem_ctrl

Overview:
- On-chip-instrumentation memory controller directly downstream of the Nios JTAG debug module wrapper.
- Decodes the wrapper's `jdo` / `take_action_ocimem_*` strobes into reads and writes of a small debug RAM.
- Shares that RAM with the CPU's Avalon debug slave port.
- Returns read data, `monitor_ready` and `monitor_error` to the debug module's TCK-side capture path.

Parameters:
- ADDR_W, 8, word-address width of the debug RAM (depth = 2**ADDR_W words of 32 bits)
- INIT_FILE, "", optional RAM init file; empty leaves RAM contents undefined (bench must write before reading)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- jdo  in  38  debug data from the JTAG wrapper, sampled only on a strobe
- take_action_ocimem_a  in  1  address-load strobe, optional read
- take_action_ocimem_b  in  1  write-data strobe
- take_no_action_ocimem_a  in  1  read-next strobe
- MonDReg  out  32  monitor data register (last read data or last written data)
- monitor_ready  out  1  last JTAG operation complete
- monitor_error  out  1  sticky: JTAG strobe dropped while busy
- avs_address  in  ADDR_W  CPU word address
- avs_read  in  1  CPU read request
- avs_write  in  1  CPU write request
- avs_writedata  in  32  CPU write data
- avs_byteenable  in  4  CPU byte lanes
- avs_readdata  out  32  CPU read data
- avs_waitrequest  out  1  CPU stall

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, MonAReg=0, MonDReg=0, monitor_ready=1, monitor_error=0, avs_readdata=0.
  - Pending JTAG and CPU operations are discarded; RAM contents are not cleared.
- Strobes are one-cycle pulses in clk domain and are mutually exclusive; if more than one is high, priority is ocimem_b > ocimem_a > no_action_a.
- take_action_ocimem_a:
  - MonAReg <= jdo[ADDR_W+1:2]; monitor_error <= 0.
  - If jdo[35]=1, a JTAG read is queued at the new address.
- take_action_ocimem_b: MonDReg <= jdo[34:3]; a JTAG write of all 4 bytes is queued at MonAReg.
- take_no_action_ocimem_a: MonAReg <= MonAReg+1 (wraps modulo 2**ADDR_W); a read is queued at the incremented address.
- Any strobe that queues an op while state!=IDLE is dropped and sets monitor_error=1. MonAReg and MonDReg are unchanged by a dropped strobe.
- Queuing an op clears monitor_ready at the same edge.
- FSM:
  - IDLE -> REQ on an accepted queuing strobe.
  - REQ -> ACC when the CPU port is not mid-access (no CPU op in its data cycle). JTAG wins over a new CPU request in the same cycle.
  - ACC (RAM enable issued) -> DONE.
  - DONE: a read loads MonDReg from RAM data; monitor_ready <= 1; -> IDLE.
- Write completion:
  - After a write, MonAReg <= MonAReg+1 at the DONE edge (wraps).
  - The read-next strobe therefore follows an explicit read; write bursts use take_action_ocimem_b only.
- JTAG latency with CPU idle:
  - Strobe at edge T.
  - RAM access in cycle T+1.
  - monitor_ready=1 and MonDReg valid after edge T+3.
- CPU port:
  - Write completes in the granted cycle (waitrequest=0 that cycle).
  - Read: grant cycle (waitrequest=1), then data cycle with avs_readdata valid and waitrequest=0.
  - waitrequest=1 whenever JTAG owns the RAM (ACC state) or a CPU request is not yet granted.
  - Byteenable masks writes per byte.
- Simultaneous CPU and JTAG access to the same address: the ordering is the grant order. The CPU never sees a half-written word.

Test Plan:
- Reset:
  - Stimulus: assert reset_n=0 mid-ACC, then release.
  - Required: monitor_ready=1, monitor_error=0, MonDReg=0, MonAReg=0; the subsequent op behaves normally.
- JTAG write/read round trip:
  - Stimulus: ocimem_a with jdo addr=0x10, jdo[35]=0; then ocimem_b with data 0xDEADBEEF; then ocimem_a addr=0x10, jdo[35]=1.
  - Required: MonDReg=0xDEADBEEF and monitor_ready=1 exactly 3 cycles after the last strobe.
- Auto-increment and wrap:
  - Stimulus: write 0x11111111 at 0xFF via ocimem_a/ocimem_b; CPU writes 0x22222222 to addr 0; then ocimem_a addr=0xFF read, then take_no_action_ocimem_a.
  - Required: reads return 0x11111111, then 0x22222222; MonAReg=0x00 (wrapped).
- Busy drop:
  - Stimulus: ocimem_b followed next cycle by a second ocimem_b with 0x12345678.
  - Required: monitor_error=1, RAM holds only the first data, MonDReg is not 0x12345678; the next ocimem_a clears the error.
- Arbitration:
  - Stimulus: CPU read of addr 0x20 asserted in the same cycle a JTAG write to 0x20 reaches REQ.
  - Required: JTAG granted first; CPU waitrequest held; CPU readdata equals the JTAG-written value; no lost or duplicated access.
- Byte enables:
  - Stimulus: CPU write 0xAABBCCDD with byteenable=4'b0101 over an existing 0x00000000.
  - Required: JTAG read returns 0x00BB00DD.
